instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Sequences instruction fetch from the combinational instruction ROM (6-bit word address, 32-bit word).
//  Owns the PC, drives the ROM address, registers the fetched word into a one-entry valid/ready output
//  stage for decode, and handles start, halt, branch/jump redirect and fetch faults.
//  Sits between the instruction ROM and the decode stage of the MIPS core.
// PARAMETERS
//  ROM_AW     6        ROM word-address width; ROM depth = 2**ROM_AW words
//  RESET_PC   32'h0    PC value loaded on reset
//  CHK_RANGE  1        1: fetch at PC >= 4*2**ROM_AW faults; 0: address bits truncate (wrap)
// PORTS
//  clk             in   1       clock, rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  start           in   1       pulse; leaves IDLE
//  halt_req        in   1       level; suspend new fetches while high
//  redirect_valid  in   1       branch/jump taken this cycle
//  redirect_pc     in   32      byte target of redirect
//  rom_addr        out  ROM_AW  = pc[ROM_AW+1:2], combinational from PC register
//  rom_data        in   32      ROM word for rom_addr, same cycle
//  instr           out  32      registered instruction
//  instr_pc        out  32      byte PC of instr
//  instr_valid     out  1       instr/instr_pc valid
//  instr_ready     in   1       decode accepts; transfer when valid & ready
//  fault           out  1       sticky fetch fault
//  state_o         out  2       IDLE=0, RUN=1, HALTED=2, FAULT=3
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fault=0, state=IDLE.
//  can_load = !instr_valid | instr_ready.  fire = (state==RUN) & can_load & !redirect_valid & !halt_req.
//  fire: instr<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (mod 2**32).
//  Not fire, instr_valid & instr_ready: instr_valid<=0.  instr_valid & !instr_ready: hold all outputs, pc.
//  Redirect (any state but FAULT), priority over fetch/halt/start:
//   redirect_pc[1:0]!=0 -> state<=FAULT, fault<=1, instr_valid<=0, pc unchanged.
//   else pc<=redirect_pc, instr_valid<=0 (flush, even if un-accepted). One-bubble latency:
//   redirect at edge k -> target word valid after edge k+1 (if RUN, ready, no halt).
//  FSM:
//   IDLE:   start -> RUN. No fetch. Redirect loads pc, stays IDLE unless start same cycle.
//   RUN:    halt_req -> HALTED (no fire that cycle). Range fault -> FAULT.
//   HALTED: no fetch; output stage drains normally; !halt_req -> RUN.
//   FAULT:  no fetch, redirect/start ignored, fault=1, instr_valid=0; exits only via rst_n.
//  Range fault (CHK_RANGE=1): in RUN with can_load & !redirect_valid & !halt_req and pc >= 4*2**ROM_AW
//   -> FAULT, fault<=1, no load. CHK_RANGE=0: rom_addr truncates, fetch proceeds.
//  Simultaneous: redirect+halt -> redirect applied, state HALTED. Redirect+start in IDLE -> RUN at new pc.
//   Redirect+instr_ready on valid word -> that word is transferred, then flushed.
//  Reset mid-operation: all state returns to reset values immediately, no partial transfer.
//  Throughput: 1 instr/cycle when instr_ready held high.
// STRUCTURE
//  Package fetch_pkg: state enum (IDLE/RUN/HALTED/FAULT), INSTR_W=32, PC_W=32, PC_STEP=4.
//  Sub-module fetch_out_reg: one-entry valid/ready holding register (load, flush, data, pc).
//  PC register, FSM and fault logic stay in instr_fetch_ctrl.
// TESTING
//  1 Reset, start, instr_ready=1, ROM[i]=32'hA000_0000+i -> instr_pc 0,4,8... one per cycle, instr matches.
//  2 instr_ready=0 for 3 cycles at instr_pc=8 -> instr/instr_pc stable, pc stays 12; release -> 12 next.
//  3 redirect_pc=32'h20 while word at 4 pending -> instr_valid=0 next cycle, then instr_pc=32'h20.
//  4 redirect_pc=32'h22 -> fault=1, state_o=3, instr_valid=0; later start/redirect ignored until rst_n.
//  5 CHK_RANGE=1, jump to 32'hFC -> word 63 fetched, next fetch (pc=32'h100) -> fault=1; CHK_RANGE=0 -> rom_addr=0.
//  6 halt_req with redirect same cycle -> HALTED, pc=target, no fetch; drop halt -> target fetched; rst_n mid-run -> all reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready holding register between the ROM and the decode stage.
module fetch_out_reg
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_flush,
    input  logic               i_ready,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_can_load
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;

    assign o_can_load = !r_valid || i_ready;
    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc       = r_pc;

    // NOTE: every state register here is a plain flop, so all of them take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            // A word accepted on this same edge has already transferred; only valid drops.
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the ROM and handles start/halt/redirect/fault.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              ROM_AW    = 6,
    parameter logic [PC_W-1:0] RESET_PC  = 32'h0,
    parameter bit              CHK_RANGE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt_req,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               fault,
    output logic [1:0]         state_o
);

    fetch_state_e    r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_fault;

    logic w_can_load;
    logic w_out_of_range;
    logic w_misaligned;
    logic w_try;
    logic w_fire;
    logic w_range_fault;
    logic w_redirect_ok;
    logic w_flush;

    assign rom_addr = r_pc[ROM_AW+1:2];
    assign fault    = r_fault;
    assign state_o  = r_state;

    // Any PC bit above the ROM's byte range means the fetch would fall off the end.
    assign w_out_of_range = CHK_RANGE && (r_pc[PC_W-1:ROM_AW+2] != '0);
    assign w_misaligned   = (redirect_pc[1:0] != 2'b00);
    assign w_try          = (r_state == ST_RUN) && w_can_load && !redirect_valid && !halt_req;
    assign w_fire         = w_try && !w_out_of_range;
    assign w_range_fault  = w_try && w_out_of_range;
    assign w_redirect_ok  = redirect_valid && (r_state != ST_FAULT);
    assign w_flush        = w_redirect_ok || w_range_fault;

    fetch_out_reg u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_fire),
        .i_flush    (w_flush),
        .i_ready    (instr_ready),
        .i_instr    (rom_data),
        .i_pc       (r_pc),
        .o_valid    (instr_valid),
        .o_instr    (instr),
        .o_pc       (instr_pc),
        .o_can_load (w_can_load)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else if (r_state != ST_FAULT) begin
            if (redirect_valid && w_misaligned) begin
                r_state <= ST_FAULT;
                r_fault <= 1'b1;
            end else begin
                if (redirect_valid) begin
                    r_pc <= redirect_pc;
                end else if (w_fire) begin
                    r_pc <= r_pc + PC_STEP;
                end
                case (r_state)
                    ST_IDLE: begin
                        if (start) r_state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (halt_req) begin
                            r_state <= ST_HALTED;
                        end else if (w_range_fault) begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                        end
                    end
                    ST_HALTED: begin
                        if (!halt_req) r_state <= ST_RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural fetch model.
module tb_instr_fetch_ctrl;

    localparam int S_IDLE    = 0;
    localparam int S_RUN     = 1;
    localparam int S_HALTED  = 2;
    localparam int S_FAULT   = 3;
    localparam int ROM_WORDS = 64;
    localparam int ROM_BYTES = 4 * ROM_WORDS;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_ready = 1'b0;

    logic [5:0]  rom_addr, rom_addr2;
    logic [31:0] rom_data, rom_data2;
    logic [31:0] instr, instr2, instr_pc, instr_pc2;
    logic        instr_valid, instr_valid2, fault, fault2;
    logic [1:0]  state_o, state2;

    logic [31:0] rom [ROM_WORDS];
    assign rom_data  = rom[rom_addr];
    assign rom_data2 = rom[rom_addr2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: post-edge architectural view of the fetch unit
    int          m_state;
    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_fault;
    xfer_t       m_slot;
    xfer_t       exp_q[$];

    always #5 clk = ~clk;

    instr_fetch_ctrl #(.ROM_AW(6), .RESET_PC(32'h0), .CHK_RANGE(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rom_addr(rom_addr), .rom_data(rom_data), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .fault(fault), .state_o(state_o)
    );

    instr_fetch_ctrl #(.ROM_AW(6), .RESET_PC(32'h0), .CHK_RANGE(1'b0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .instr(instr2), .instr_pc(instr_pc2),
        .instr_valid(instr_valid2), .instr_ready(instr_ready), .fault(fault2), .state_o(state2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_fault = 1'b0;
        exp_q.delete();
    endtask

    // Applies the spec rules for one rising edge, using the inputs the DUT saw at that edge.
    task automatic model_edge();
        bit can_load;
        bit drained;
        can_load = !m_valid || instr_ready;
        drained  = m_valid && instr_ready;
        if (m_state == S_FAULT) return;
        if (redirect_valid) begin
            m_valid = 1'b0;
            if (redirect_pc % 4 != 0) begin
                m_state = S_FAULT;
                m_fault = 1'b1;
            end else begin
                m_pc = redirect_pc;
                if (m_state == S_IDLE) m_state = start ? S_RUN : S_IDLE;
                else                   m_state = halt_req ? S_HALTED : S_RUN;
            end
            return;
        end
        if (drained) m_valid = 1'b0;
        if (m_state == S_IDLE) begin
            if (start) m_state = S_RUN;
        end else if (m_state == S_HALTED) begin
            if (!halt_req) m_state = S_RUN;
        end else if (halt_req) begin
            m_state = S_HALTED;
        end else if (can_load) begin
            if (m_pc >= ROM_BYTES) begin
                m_state = S_FAULT;
                m_fault = 1'b1;
                m_valid = 1'b0;
            end else begin
                m_slot.instr = rom[(m_pc / 4) % ROM_WORDS];
                m_slot.pc    = m_pc;
                m_valid      = 1'b1;
                m_pc         = m_pc + 4;
            end
        end
    endtask

    // One clock of stimulus; expected transfers are queued when the model predicts them.
    task automatic cyc(input bit st, input bit hl, input bit rv, input logic [31:0] rpc, input bit rdy);
        start          = st;
        halt_req       = hl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        if (m_valid && rdy) exp_q.push_back(m_slot);
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_state", 32'(state_o), S_IDLE);
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        model_reset();
        start          = 1'b0;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    // Monitor: compares the visible state every cycle and pops on each valid/ready transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            check("state_o", 32'(state_o), m_state);
            check("fault", 32'(fault), 32'(m_fault));
            check("instr_valid", 32'(instr_valid), 32'(m_valid));
            check("rom_addr", 32'(rom_addr), (m_pc / 4) % ROM_WORDS);
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer_pc", instr_pc, 32'hFFFF_FFFF);
                end else begin
                    xfer_t e;
                    e = exp_q.pop_front();
                    check("xfer_instr", instr, e.instr);
                    check("xfer_pc", instr_pc, e.pc);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < ROM_WORDS; i++) rom[i] = 32'hA000_0000 + i;
        #2;
        do_reset();

        // Streaming, then back-pressure on the word at 8
        cyc(1, 0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 1);

        // Redirect while the word at 4 is still pending
        do_reset();
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'h20, 0);
        repeat (4) cyc(0, 0, 0, 0, 1);

        // Misaligned redirect faults; later start/redirect must be ignored
        do_reset();
        cyc(1, 0, 0, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'h22, 1);
        cyc(1, 0, 1, 32'h40, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);

        // Top of ROM: checked instance faults at 0x100, wrapping instance reads word 0
        do_reset();
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'hFC, 1);
        cyc(0, 0, 0, 0, 1);
        check("wrap_rom_addr", 32'(rom_addr2), 32'h0);
        check("wrap_fault", 32'(fault2), 32'h0);
        check("wrap_state", 32'(state2), S_RUN);
        repeat (3) cyc(0, 0, 0, 0, 1);

        // Halt with redirect, resume at target, then reset mid-run
        do_reset();
        cyc(1, 0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 1, 32'h40, 1);
        repeat (3) cyc(0, 1, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        do_reset();

        // Random traffic with periodic resets and fresh ROM contents
        for (int blk = 0; blk < 12; blk++) begin
            do_reset();
            for (int i = 0; i < ROM_WORDS; i++) rom[i] = $urandom;
            cyc(1, 0, 0, 0, 1);
            for (int c = 0; c < 250; c++) begin
                bit          st, hl, rv, rdy;
                logic [31:0] rpc;
                logic [31:0] rnd;
                st  = ($urandom_range(0, 19) == 0);
                hl  = ($urandom_range(0, 4) == 0);
                rv  = ($urandom_range(0, 9) == 0);
                rdy = ($urandom_range(0, 3) != 0);
                rnd = $urandom;
                if ($urandom_range(0, 49) == 0) rpc = {rnd[31:2], 2'b01};
                else                            rpc = 32'($urandom_range(0, 80)) * 4;
                cyc(st, hl, rv, rpc, rdy);
            end
        end

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
